// File: rtl/gpio_in_filter.sv
// Per-pin input conditioner: 2-flop synchronizer, optional debounce filter and
// single-cycle rise/fall pulses for each GPIO lane.
module gpio_in_filter #(
   parameter int unsigned NUM_PINS = 8,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_PINS-1:0] pin_i,
   input  logic [NUM_PINS-1:0] filt_en_i,
   input  logic [CNT_W-1:0]    debounce_cyc_i,
   output logic [NUM_PINS-1:0] pin_o,
   output logic [NUM_PINS-1:0] rise_o,
   output logic [NUM_PINS-1:0] fall_o,
   output logic                edge_any_o
);

   logic [NUM_PINS-1:0] sync1_q, sync2_q;
   logic [NUM_PINS-1:0] pin_q, pin_d;
   logic [NUM_PINS-1:0] rise_q, rise_d;
   logic [NUM_PINS-1:0] fall_q, fall_d;
   logic [CNT_W-1:0]    cnt_q [NUM_PINS];
   logic [CNT_W-1:0]    cnt_d [NUM_PINS];

   // Per-lane debounce: commit sync2 once it has differed for more than D cycles.
   always_comb begin
      pin_d = pin_q;
      for (int i = 0; i < int'(NUM_PINS); i++) begin
         cnt_d[i] = '0;
         if (!filt_en_i[i]) begin
            pin_d[i] = sync2_q[i];
         end else if (sync2_q[i] != pin_q[i]) begin
            if (cnt_q[i] >= debounce_cyc_i) begin
               pin_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      rise_d = ~pin_q & pin_d;
      fall_d = pin_q & ~pin_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pin_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < int'(NUM_PINS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         pin_q   <= pin_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < int'(NUM_PINS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pin_o      = pin_q;
   assign rise_o     = rise_q;
   assign fall_o     = fall_q;
   assign edge_any_o = |(rise_q | fall_q);

endmodule
